// File: rtl/complex_gate_pkg.sv
// Shared types for the complex-gate pipeline: function-select enum
// and the popcount result width helper.
package complex_gate_pkg;

   typedef enum logic [1:0] {
      MODE_AND_OR = 2'd0,
      MODE_AOI    = 2'd1,
      MODE_OR_AND = 2'd2,
      MODE_OAI    = 2'd3
   } mode_e;

   function automatic int ones_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/complex_gate_eval.sv
// Combinational AND-OR / AOI / OR-AND / OAI evaluator,
// bitwise over WIDTH bits.
module complex_gate_eval
   import complex_gate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  mode_e             mode,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [WIDTH-1:0]  c,
   output logic [WIDTH-1:0]  y
);

   always_comb begin
      y = '0;
      unique case (mode)
         MODE_AND_OR: y = a & (b | c);
         MODE_AOI:    y = ~(a & (b | c));
         MODE_OR_AND: y = a | (b & c);
         MODE_OAI:    y = ~(a | (b & c));
      endcase
   end

endmodule

// File: rtl/complex_gate_pipe.sv
// Two-stage valid/ready complex-gate pipeline with result popcount.
// Optional output-transfer counter under COMPLEX_GATE_PIPE_STATS_EN.
module complex_gate_pipe
   import complex_gate_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 in_mode,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   input  logic [WIDTH-1:0]           in_c,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_y,
   output logic [ones_w(WIDTH)-1:0]   out_ones,
   input  logic                       stat_clr,
   output logic [CNT_W-1:0]           stat_cnt
);

   localparam int OW = ones_w(WIDTH);

   logic             s1_vld;
   mode_e            s1_mode;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] s1_c;
   logic             s2_vld;
   logic [WIDTH-1:0] s2_y;
   logic [OW-1:0]    s2_ones;
   logic [WIDTH-1:0] y;
   logic [OW-1:0]    ones;
   logic             out_xfer;
   logic             s2_load;

   assign out_xfer  = s2_vld & out_ready;
   assign s2_load   = ~s2_vld | out_xfer;
   assign in_ready  = ~s1_vld | s2_load;
   assign out_valid = s2_vld;
   assign out_y     = s2_y;
   assign out_ones  = s2_ones;

   complex_gate_eval #(.WIDTH(WIDTH)) u_eval (
      .mode (s1_mode),
      .a    (s1_a),
      .b    (s1_b),
      .c    (s1_c),
      .y    (y)
   );

   always_comb begin
      ones = '0;
      for (int i = 0; i < WIDTH; i++)
         ones = ones + OW'(y[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_mode <= MODE_AND_OR;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_c    <= '0;
      end else if (in_ready) begin
         s1_vld <= in_valid;
         if (in_valid) begin
            s1_mode <= mode_e'(in_mode);
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_c    <= in_c;
         end
      end
   end

   // Result regs only change when a real word moves in, so an
   // emptied S2 keeps its last value rather than bubble garbage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld  <= 1'b0;
         s2_y    <= '0;
         s2_ones <= '0;
      end else if (s2_load) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_y    <= y;
            s2_ones <= ones;
         end
      end
   end

`ifdef COMPLEX_GATE_PIPE_STATS_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (stat_clr)
         cnt <= '0;
      else if (out_xfer && cnt != '1)
         cnt <= cnt + 1'b1;
   end

   assign stat_cnt = cnt;
`else
   logic unused_stat_clr;

   assign unused_stat_clr = stat_clr;
   assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_complex_gate_pipe.sv
// Table-driven scoreboard bench for complex_gate_pipe (WIDTH=8, CNT_W=4).
// Checks the counter when COMPLEX_GATE_PIPE_STATS_EN is defined.
module tb_complex_gate_pipe;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
      logic [7:0] y;
      logic [3:0] ones;
   } vec_t;

   typedef struct {
      logic [7:0] y;
      logic [3:0] ones;
      bit         lat;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] in_mode = 2'd0;
   logic [7:0] in_a = 8'h00;
   logic [7:0] in_b = 8'h00;
   logic [7:0] in_c = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_y;
   logic [3:0] out_ones;
   logic       stat_clr = 1'b0;
   logic [3:0] stat_cnt;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   lat_chk = 0;
   bit   rdy_chk = 0;
   vec_t cur;
   vec_t tbl[10];
   exp_t exp_q[$];

   complex_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_ones  (out_ones),
      .stat_clr  (stat_clr),
      .stat_cnt  (stat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   // Scoreboard: push on accepted input, pop on output transfer.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_out: got y=%h, want none", out_y);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (out_y !== e.y || out_ones !== e.ones) begin
                  n_err++;
                  $display("FAIL out_data: got y=%h ones=%0d, want y=%h ones=%0d",
                           out_y, out_ones, e.y, e.ones);
               end else if (e.lat && cyc != e.cyc + 2) begin
                  n_err++;
                  $display("FAIL latency: got %0d cycles, want 2", cyc - e.cyc);
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_t e;
            e.y    = cur.y;
            e.ones = cur.ones;
            e.lat  = lat_chk;
            e.cyc  = cyc;
            exp_q.push_back(e);
         end
      end
      cyc++;
   end

   // Presents a word, returns just after the edge that accepts it.
   task automatic send(input vec_t v);
      bit done;
      done     = 0;
      cur      = v;
      in_mode  = v.mode;
      in_a     = v.a;
      in_b     = v.b;
      in_c     = v.c;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (rdy_chk) check("in_ready_const", in_ready, 1);
         if (in_ready) done = 1;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: got in_ready=0, want 1");
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit done;
      done      = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) done = 1;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0] = '{2'd0, 8'hF0, 8'h3C, 8'h00, 8'h30, 4'd2};
      tbl[1] = '{2'd1, 8'hF0, 8'h3C, 8'h00, 8'hCF, 4'd6};
      tbl[2] = '{2'd2, 8'hF0, 8'h3C, 8'h00, 8'hF0, 4'd4};
      tbl[3] = '{2'd3, 8'hF0, 8'h3C, 8'h00, 8'h0F, 4'd4};
      tbl[4] = '{2'd0, 8'hFF, 8'h0F, 8'hF0, 8'hFF, 4'd8};
      tbl[5] = '{2'd1, 8'hFF, 8'h0F, 8'hF0, 8'h00, 4'd0};
      tbl[6] = '{2'd2, 8'h00, 8'hAA, 8'h0F, 8'h0A, 4'd2};
      tbl[7] = '{2'd3, 8'h00, 8'hAA, 8'h0F, 8'hF5, 4'd6};
      tbl[8] = '{2'd1, 8'hAA, 8'h55, 8'h00, 8'hFF, 4'd8};
      tbl[9] = '{2'd3, 8'h12, 8'h34, 8'h56, 8'hE9, 4'd5};
      cur = tbl[0];

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_ones", out_ones, 0);
      check("rst_stat_cnt", stat_cnt, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1);
      @(posedge clk);
      #1;

      // Back-to-back table, latency 2, no bubbles
      out_ready = 1'b1;
      lat_chk   = 1;
      rdy_chk   = 1;
      for (int i = 0; i < 10; i++) send(tbl[i]);
      rdy_chk = 0;
      drain();
      lat_chk = 0;

      // Mode changes while idle produce nothing
      for (int i = 0; i < 4; i++) begin
         in_mode = 2'(i);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("idle_no_output", out_valid, 0);
      @(posedge clk);
      #1;

      // Backpressure: two held, third blocked, order kept
      out_ready = 1'b0;
      send(tbl[4]);
      send(tbl[6]);
      cur      = tbl[9];
      in_mode  = tbl[9].mode;
      in_a     = tbl[9].a;
      in_b     = tbl[9].b;
      in_c     = tbl[9].c;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         check("bp_out_y_stable", out_y, tbl[4].y);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();

`ifdef COMPLEX_GATE_PIPE_STATS_EN
      // 13 transfers so far; 20 more must saturate at 15
      check("stat_before_sat", stat_cnt, 13);
      for (int i = 0; i < 20; i++) send(tbl[i % 10]);
      drain();
      check("stat_saturated", stat_cnt, 15);
      out_ready = 1'b0;
      send(tbl[1]);
      idle(2);
      out_ready = 1'b1;
      stat_clr  = 1'b1;
      @(negedge clk);
      check("clr_xfer_valid", out_valid, 1);
      @(posedge clk);
      #1 stat_clr = 1'b0;
      @(negedge clk);
      check("stat_clr_priority", stat_cnt, 0);
      send(tbl[2]);
      drain();
      check("stat_after_clr", stat_cnt, 1);
`else
      check("stat_zero_a", stat_cnt, 0);
      stat_clr = 1'b1;
      for (int i = 0; i < 5; i++) send(tbl[i]);
      stat_clr = 1'b0;
      drain();
      check("stat_zero_b", stat_cnt, 0);
`endif

      // Reset with both stages full discards everything
      out_ready = 1'b0;
      send(tbl[7]);
      send(tbl[8]);
      in_valid = 1'b0;
      @(negedge clk);
      check("full_out_valid", out_valid, 1);
      check("full_in_ready", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_stat_cnt", stat_cnt, 0);
      check("midrst_out_y", out_y, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1);
      repeat (8) @(negedge clk);
      check("midrst_no_ghost", out_valid, 0);
      check("midrst_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
